// File: rtl/decrypt_session_ctrl.sv
// decrypt_session_ctrl: sequences one decrypt session through the processor wrapper --
// byte-stream load, RAM write burst, program execution under a timeout, plaintext read-back.
module decrypt_session_ctrl #(
    parameter int          BUF_LEN        = 108,
    parameter logic [11:0] RESULT_BASE    = 12'd1700,
    parameter int          RESULT_LEN     = 108,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [4:0]  shift_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [1:0]  cpu_en,
    output logic [7:0]  char_buffer_data,
    output logic [4:0]  shift_amt_data,
    output logic [1:0]  program_sel,
    output logic [11:0] read_addr,
    input  logic [31:0] read_data,
    input  logic        done_flag,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        error
);

    localparam logic [1:0] CPU_IDLE  = 2'b00;
    localparam logic [1:0] CPU_WRITE = 2'b01;
    localparam logic [1:0] CPU_EXEC  = 2'b10;
    localparam logic [1:0] MODE_EN   = 2'b01;
    localparam logic [1:0] MODE_BF   = 2'b10;

    localparam logic [6:0]  BUF_LAST = 7'(BUF_LEN - 1);
    localparam logic [6:0]  RES_LAST = 7'(RESULT_LEN - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WRITE,
        S_EXEC,
        S_RD_ADDR,
        S_RD_CAPT,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t      state, next_state;
    logic [1:0]  mode_q;
    logic [4:0]  shift_q;
    logic [6:0]  ld_idx, wr_idx, rd_idx;
    logic [19:0] to_cnt;
    logic [7:0]  buf_mem [BUF_LEN];

    logic start_ok;
    logic rx_fire;
    logic timeout_hit;
    logic unused_read_bits;

    assign start_ok         = start && (mode == MODE_EN || mode == MODE_BF);
    assign rx_fire          = rx_valid && rx_ready;
    assign timeout_hit      = (to_cnt == TO_LAST);
    assign program_sel      = mode_q;
    assign unused_read_bits = ^read_data[31:8];

    // NOTE: every clocked process assigns with <= so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start_ok) next_state = S_LOAD;
            S_LOAD: begin
                if (rx_fire && ld_idx == BUF_LAST)
                    next_state = (mode_q == MODE_EN) ? S_SHIFT : S_WRITE;
            end
            S_SHIFT:   next_state = S_WRITE;
            S_WRITE:   if (wr_idx == BUF_LAST) next_state = S_EXEC;
            S_EXEC: begin
                // Completion beats a coincident timeout.
                if (done_flag)        next_state = S_RD_ADDR;
                else if (timeout_hit) next_state = S_DONE;
            end
            S_RD_ADDR: next_state = S_RD_CAPT;
            S_RD_CAPT: next_state = S_RD_HOLD;
            S_RD_HOLD: begin
                if (tx_ready)
                    next_state = (rd_idx == RES_LAST) ? S_DONE : S_RD_ADDR;
            end
            S_DONE:    next_state = S_DONE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: all outputs get a default before the case so no path leaves one unassigned.
    always_comb begin
        rx_ready         = 1'b0;
        cpu_en           = CPU_IDLE;
        shift_amt_data   = '0;
        char_buffer_data = '0;
        read_addr        = '0;
        busy             = 1'b1;
        case (state)
            S_IDLE, S_DONE: busy = 1'b0;
            S_LOAD:         rx_ready = 1'b1;
            // A nonzero shift overrides CPU register writes, so it is driven for this cycle only.
            S_SHIFT:        shift_amt_data = shift_q;
            S_WRITE: begin
                cpu_en           = CPU_WRITE;
                char_buffer_data = buf_mem[wr_idx];
            end
            S_EXEC:         cpu_en = CPU_EXEC;
            S_RD_ADDR:      read_addr = RESULT_BASE + {5'd0, rd_idx};
            default:        ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q   <= '0;
            shift_q  <= '0;
            error    <= 1'b0;
            ld_idx   <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            to_cnt   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mode_q  <= mode;
                        shift_q <= shift_in;
                        error   <= 1'b0;
                        ld_idx  <= '0;
                        wr_idx  <= '0;
                        rd_idx  <= '0;
                        to_cnt  <= '0;
                    end
                end
                S_LOAD:  if (rx_fire) ld_idx <= ld_idx + 7'd1;
                S_WRITE: wr_idx <= wr_idx + 7'd1;
                S_EXEC: begin
                    to_cnt <= to_cnt + 20'd1;
                    if (timeout_hit && !done_flag) error <= 1'b1;
                end
                S_RD_CAPT: begin
                    tx_data  <= read_data[7:0];
                    tx_valid <= 1'b1;
                end
                S_RD_HOLD: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        rd_idx   <= rd_idx + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the byte buffer has no reset; LOAD rewrites every entry before WRITE reads it.
    always_ff @(posedge clock) begin
        if (state == S_LOAD && rx_fire) buf_mem[ld_idx] <= rx_data;
    end

endmodule

// File: tb/tb_decrypt_session_ctrl.sv
// Self-checking bench for decrypt_session_ctrl: randomized sessions scored against a
// transaction-level model (byte queues, cycle counts, address arithmetic).
module tb_decrypt_session_ctrl;

    localparam int BUF_LEN = 108;
    localparam int RES_LEN = 108;
    localparam int RES_BASE = 1700;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  shift_in = 5'd0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, tx_ready = 1'b0, done_flag = 1'b0;
    logic [31:0] read_data = 32'd0;
    logic        rx_ready, tx_valid, busy, error;
    logic [1:0]  cpu_en, program_sel;
    logic [7:0]  char_buffer_data, tx_data;
    logic [4:0]  shift_amt_data;
    logic [11:0] read_addr;

    logic        t_reset = 1'b1, t_start = 1'b0, t_done_flag = 1'b0;
    logic [31:0] t_read_data = 32'd0;
    logic        t_rx_ready, t_tx_valid, t_busy, t_error;
    logic [1:0]  t_cpu_en, t_program_sel;
    logic [7:0]  t_char_buffer_data, t_tx_data;
    logic [4:0]  t_shift_amt_data;
    logic [11:0] t_read_addr;

    decrypt_session_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .shift_in(shift_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .cpu_en(cpu_en),
        .char_buffer_data(char_buffer_data), .shift_amt_data(shift_amt_data),
        .program_sel(program_sel), .read_addr(read_addr), .read_data(read_data),
        .done_flag(done_flag), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .error(error)
    );

    decrypt_session_ctrl #(.TIMEOUT_CYCLES(20)) dut_to (
        .clock(clock), .reset(t_reset), .start(t_start), .mode(mode), .shift_in(shift_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(t_rx_ready), .cpu_en(t_cpu_en),
        .char_buffer_data(t_char_buffer_data), .shift_amt_data(t_shift_amt_data),
        .program_sel(t_program_sel), .read_addr(t_read_addr), .read_data(t_read_data),
        .done_flag(t_done_flag), .tx_data(t_tx_data), .tx_valid(t_tx_valid), .tx_ready(tx_ready),
        .busy(t_busy), .error(t_error)
    );

    // RAM model: synchronous read returning 0x100 + address one cycle later.
    always @(posedge clock) read_data <= 32'h100 + {20'd0, read_addr};

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cipher_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] tx_q[$];
    int shift_cnt, shift_cyc, last_hs_cyc, first_wr_cyc, exec_cnt, hold_viol, psel_bad;
    int tx_valid_cnt, extra_acc;
    logic [4:0]  shift_val;
    logic [11:0] first_rd_addr;
    bit          budget_hit;

    function automatic logic [7:0] exp_plain(input int i);
        int v;
        v = 'h100 + RES_BASE + i;
        return v[7:0];
    endfunction

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; done_flag = 1'b0;
        mode = 2'b00; shift_in = 5'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one full session on dut and records what it observed cycle by cycle.
    task automatic run_session(input logic [1:0] m, input logic [4:0] sh, input int done_at,
                               input bit rx_rand, input int tx_mode, input bit noisy,
                               input bit inject);
        int idx = 0;
        bit prev_exec = 1'b0, prev_hold = 1'b0, injected = 1'b0, ended = 1'b0;
        logic [7:0] prev_data = 8'h00;
        wr_q.delete(); tx_q.delete();
        shift_cnt = 0; shift_cyc = -1; last_hs_cyc = -1; first_wr_cyc = -1; exec_cnt = 0;
        hold_viol = 0; psel_bad = 0; tx_valid_cnt = 0; extra_acc = 0; shift_val = 5'd0;
        first_rd_addr = 12'hfff; budget_hit = 1'b0;
        @(negedge clock);
        start = 1'b1; mode = m; shift_in = sh;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 0) begin mode = 2'b00; shift_in = 5'd0; end
            if (inject && !injected && idx == 20) begin
                start = 1'b1; mode = 2'b10; shift_in = 5'd7; injected = 1'b1;
            end
            if (idx < BUF_LEN) begin
                rx_valid = !rx_rand || ($urandom_range(3, 0) != 0);
                rx_data  = cipher_q[idx];
                if (rx_valid && rx_ready) begin idx++; last_hs_cyc = cyc; end
            end else begin
                rx_valid = noisy;
                rx_data  = 8'($urandom);
                if (rx_valid && rx_ready) extra_acc++;
            end
            if (shift_amt_data != 5'd0) begin shift_cnt++; shift_val = shift_amt_data; shift_cyc = cyc; end
            if (cpu_en == 2'b01) begin
                wr_q.push_back(char_buffer_data);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (busy && program_sel != m) psel_bad++;
            if (cpu_en == 2'b10) begin
                exec_cnt++;
                done_flag = (exec_cnt == done_at);
            end else begin
                done_flag = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            if (prev_exec && cpu_en != 2'b10) first_rd_addr = read_addr;
            prev_exec = (cpu_en == 2'b10);
            tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? cyc[1] : 1'($urandom_range(1, 0));
            if (prev_hold && (!tx_valid || tx_data !== prev_data)) hold_viol++;
            if (tx_valid) tx_valid_cnt++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (!busy) begin ended = 1'b1; break; end
        end
        budget_hit = !ended;
        rx_valid = 1'b0; done_flag = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 2'b01; rx_valid = 1'b1; done_flag = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (cpu_en !== 2'b00) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 00", cpu_en); end
        n_checks++; if (program_sel !== 2'b00) begin n_fail++; $display("FAIL reset_program_sel: got %b want 00", program_sel); end
        n_checks++; if (shift_amt_data !== 5'd0) begin n_fail++; $display("FAIL reset_shift: got %0d want 0", shift_amt_data); end
        n_checks++; if (char_buffer_data !== 8'd0 || read_addr !== 12'd0) begin n_fail++; $display("FAIL reset_data_addr: got %h/%h want 0/0", char_buffer_data, read_addr); end
        n_checks++; if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_handshakes: rx_ready %b tx_valid %b want 0/0", rx_ready, tx_valid); end
        n_checks++; if (tx_data !== 8'd0 || busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_status: tx_data %h busy %b error %b want 0", tx_data, busy, error); end
        apply_reset();
    endtask

    task automatic test_bf_session();
        int bad_wr = 0, bad_tx = 0;
        cipher_q.delete();
        for (int i = 0; i < BUF_LEN; i++) cipher_q.push_back(8'(8'h41 + i));
        run_session(2'b10, 5'd0, 50, 1'b0, 1, 1'b0, 1'b0);
        n_checks++; if (budget_hit) begin n_fail++; $display("FAIL bf_timeout: session did not end within budget"); end
        n_checks++; if (wr_q.size() != BUF_LEN) begin n_fail++; $display("FAIL bf_write_len: got %0d want %0d", wr_q.size(), BUF_LEN); end
        for (int i = 0; i < wr_q.size() && i < BUF_LEN; i++) if (wr_q[i] !== 8'(8'h41 + i)) bad_wr++;
        n_checks++; if (bad_wr != 0) begin n_fail++; $display("FAIL bf_write_bytes: %0d wrong bytes want 0", bad_wr); end
        n_checks++; if (first_wr_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL bf_write_start: cycle %0d want %0d", first_wr_cyc, last_hs_cyc + 1); end
        n_checks++; if (shift_cnt != 0) begin n_fail++; $display("FAIL bf_no_shift: got %0d shift cycles want 0", shift_cnt); end
        n_checks++; if (exec_cnt != 50) begin n_fail++; $display("FAIL bf_exec_len: got %0d want 50", exec_cnt); end
        n_checks++; if (first_rd_addr !== 12'(RES_BASE)) begin n_fail++; $display("FAIL bf_first_addr: got %0d want %0d", first_rd_addr, RES_BASE); end
        n_checks++; if (tx_q.size() != RES_LEN) begin n_fail++; $display("FAIL bf_tx_len: got %0d want %0d", tx_q.size(), RES_LEN); end
        for (int i = 0; i < tx_q.size() && i < RES_LEN; i++) if (tx_q[i] !== exp_plain(i)) bad_tx++;
        n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL bf_tx_bytes: %0d wrong bytes want 0", bad_tx); end
        n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL bf_tx_hold: %0d unstable cycles want 0", hold_viol); end
        n_checks++; if (psel_bad != 0) begin n_fail++; $display("FAIL bf_program_sel: %0d cycles not 10 want 0", psel_bad); end
        n_checks++; if (error !== 1'b0 || cpu_en !== 2'b00) begin n_fail++; $display("FAIL bf_done_state: error %b cpu_en %b want 0/00", error, cpu_en); end
    endtask

    task automatic test_start_in_done();
        @(negedge clock); start = 1'b1; mode = 2'b01; shift_in = 5'd3; rx_valid = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: busy %b rx_ready %b want 0/0", busy, rx_ready); end
        n_checks++; if (program_sel !== 2'b10 || cpu_en !== 2'b00) begin n_fail++; $display("FAIL done_start_latch: program_sel %b cpu_en %b want 10/00", program_sel, cpu_en); end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int idx = 0, wr_cnt = 0, bad = 0;
        bit hit = 1'b0;
        apply_reset();
        @(negedge clock); start = 1'b1; mode = 2'b10;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock); start = 1'b0;
            rx_valid = (idx < BUF_LEN); rx_data = 8'(idx);
            if (rx_valid && rx_ready) idx++;
            if (cpu_en == 2'b01) wr_cnt++;
            if (wr_cnt == 40) begin hit = 1'b1; reset = 1'b1; break; end
        end
        @(negedge clock);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_write_reached: 40 write cycles not seen"); end
        n_checks++; if (cpu_en !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_write_abort: cpu_en %b busy %b want 00/0", cpu_en, busy); end
        n_checks++; if (rx_ready !== 1'b0 || char_buffer_data !== 8'd0) begin n_fail++; $display("FAIL rst_write_outputs: rx_ready %b data %h want 0/00", rx_ready, char_buffer_data); end
        reset = 1'b0; rx_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin @(negedge clock); if (cpu_en == 2'b01 || busy) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_write_quiet: %0d active cycles want 0", bad); end
    endtask

    task automatic test_en_session();
        int bad_wr = 0, bad_tx = 0, d_at;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); start = 1'b1; mode = (k == 0) ? 2'b00 : 2'b11;
            @(negedge clock); start = 1'b0;
            n_checks++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL bad_mode_start: mode %0d busy %b want 0", k * 3, busy); end
        end
        cipher_q.delete();
        for (int i = 0; i < BUF_LEN; i++) cipher_q.push_back(8'($urandom));
        d_at = $urandom_range(80, 1);
        run_session(2'b01, 5'd3, d_at, 1'b1, 2, 1'b1, 1'b1);
        n_checks++; if (budget_hit) begin n_fail++; $display("FAIL en_timeout: session did not end within budget"); end
        n_checks++; if (shift_cnt != 1 || shift_val !== 5'd3) begin n_fail++; $display("FAIL en_shift: %0d cycles value %0d want 1 cycle value 3", shift_cnt, shift_val); end
        n_checks++; if (shift_cyc != last_hs_cyc + 1 || first_wr_cyc != shift_cyc + 1) begin n_fail++; $display("FAIL en_shift_pos: hs %0d shift %0d write %0d want consecutive", last_hs_cyc, shift_cyc, first_wr_cyc); end
        n_checks++; if (wr_q.size() != BUF_LEN) begin n_fail++; $display("FAIL en_write_len: got %0d want %0d", wr_q.size(), BUF_LEN); end
        for (int i = 0; i < wr_q.size() && i < BUF_LEN; i++) if (wr_q[i] !== cipher_q[i]) bad_wr++;
        n_checks++; if (bad_wr != 0) begin n_fail++; $display("FAIL en_write_bytes: %0d wrong bytes want 0", bad_wr); end
        n_checks++; if (exec_cnt != d_at) begin n_fail++; $display("FAIL en_exec_len: got %0d want %0d", exec_cnt, d_at); end
        n_checks++; if (psel_bad != 0 || extra_acc != 0) begin n_fail++; $display("FAIL en_ignored_inputs: psel %0d extra rx %0d want 0/0", psel_bad, extra_acc); end
        n_checks++; if (tx_q.size() != RES_LEN) begin n_fail++; $display("FAIL en_tx_len: got %0d want %0d", tx_q.size(), RES_LEN); end
        for (int i = 0; i < tx_q.size() && i < RES_LEN; i++) if (tx_q[i] !== exp_plain(i)) bad_tx++;
        n_checks++; if (bad_tx != 0 || hold_viol != 0) begin n_fail++; $display("FAIL en_tx_bytes: %0d wrong %0d unstable want 0/0", bad_tx, hold_viol); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL en_error: got %b want 0", error); end
    endtask

    task automatic test_back_to_back();
        int bad_wr = 0, bad_tx = 0;
        apply_reset();
        cipher_q.delete();
        for (int i = 0; i < BUF_LEN; i++) cipher_q.push_back(8'($urandom));
        run_session(2'b10, 5'($urandom), 1, 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < wr_q.size() && i < BUF_LEN; i++) if (wr_q[i] !== cipher_q[i]) bad_wr++;
        for (int i = 0; i < tx_q.size() && i < RES_LEN; i++) if (tx_q[i] !== exp_plain(i)) bad_tx++;
        n_checks++; if (budget_hit || wr_q.size() != BUF_LEN || bad_wr != 0) begin n_fail++; $display("FAIL b2b_write: len %0d wrong %0d want %0d/0", wr_q.size(), bad_wr, BUF_LEN); end
        n_checks++; if (exec_cnt != 1 || first_rd_addr !== 12'(RES_BASE)) begin n_fail++; $display("FAIL b2b_exec: exec %0d addr %0d want 1/%0d", exec_cnt, first_rd_addr, RES_BASE); end
        n_checks++; if (tx_q.size() != RES_LEN || bad_tx != 0) begin n_fail++; $display("FAIL b2b_tx: len %0d wrong %0d want %0d/0", tx_q.size(), bad_tx, RES_LEN); end
    endtask

    task automatic test_timeout();
        int idx = 0, ex = 0, txv = 0;
        bit fin = 1'b0;
        t_reset = 1'b1; repeat (2) @(negedge clock); t_reset = 1'b0;
        @(negedge clock); t_start = 1'b1; mode = 2'b10;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock); t_start = 1'b0; mode = 2'b00; tx_ready = 1'b1;
            rx_valid = (idx < BUF_LEN); rx_data = 8'(idx);
            if (rx_valid && t_rx_ready) idx++;
            if (t_cpu_en == 2'b10) ex++;
            if (t_tx_valid) txv++;
            if (!t_busy) begin fin = 1'b1; break; end
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL to_end: session did not end within budget"); end
        n_checks++; if (ex != 20) begin n_fail++; $display("FAIL to_exec_len: got %0d want 20", ex); end
        n_checks++; if (t_error !== 1'b1 || t_cpu_en !== 2'b00) begin n_fail++; $display("FAIL to_error: error %b cpu_en %b want 1/00", t_error, t_cpu_en); end
        n_checks++; if (txv != 0) begin n_fail++; $display("FAIL to_no_tx: %0d tx_valid cycles want 0", txv); end
        t_start = 1'b1; mode = 2'b01; rx_valid = 1'b1;
        @(negedge clock); t_start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (t_busy !== 1'b0 || t_rx_ready !== 1'b0 || t_error !== 1'b1) begin n_fail++; $display("FAIL to_restart: busy %b rx_ready %b error %b want 0/0/1", t_busy, t_rx_ready, t_error); end
        rx_valid = 1'b0; t_reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bf_session();
        test_start_in_done();
        test_reset_mid_write();
        test_en_session();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
